// File: rtl/fpu_result_fifo.sv
// Capture FIFO for FPU results {tag,exc,data} with sticky fflags/overflow and a level irq.
// Latency: first-word fall-through; an entry pushed at edge N is visible on rd_* after edge N.
// Backpressure: none upstream; a push while full (and no pop) is dropped and sets overflow.
module fpu_result_fifo #(
  parameter int DEPTH      = 8,
  parameter int AW         = 3,
  parameter int IRQ_THRESH = 1
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          res_valid,
  input  logic [31:0]   res_data,
  input  logic [4:0]    res_exc,
  input  logic [3:0]    res_tag,
  input  logic          pop,
  input  logic          flush,
  input  logic          clr_flags,
  output logic [31:0]   rd_data,
  output logic [4:0]    rd_exc,
  output logic [3:0]    rd_tag,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic [4:0]    fflags,
  output logic          irq
);

  localparam logic [AW:0] DEPTH_C  = DEPTH[AW:0];
  localparam logic [AW:0] THRESH_C = IRQ_THRESH[AW:0];

  typedef struct packed {
    logic [3:0]  tag;
    logic [4:0]  exc;
    logic [31:0] data;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [4:0]      fflags_q, fflags_d;

  logic            is_empty, is_full;
  logic            pop_ok, push_ok, drop;
  logic [4:0]      exc_in;
  entry_t          head;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DEPTH_C);

  // A pop while empty is ignored; a full FIFO with a pop frees a slot for a concurrent push.
  assign pop_ok  = pop & ~is_empty & ~flush;
  assign push_ok = res_valid & ~flush & (~is_full | pop_ok);
  // Flush swallows the incoming entry silently, so it never counts as a drop.
  assign drop    = res_valid & ~flush & is_full & ~pop_ok;
  assign exc_in  = res_valid ? res_exc : 5'b0;

  // Next-state for pointers, occupancy and sticky flags.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    fflags_d   = fflags_q | exc_in;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
    // Clearing must not lose a flag or drop that arrives in the same cycle.
    if (clr_flags) begin
      overflow_d = drop;
      fflags_d   = exc_in;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      fflags_q   <= 5'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      fflags_q   <= fflags_d;
    end
  end

  // Storage array; contents after reset are don't-care, so no reset here.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && push_ok) begin
      mem_q[wr_ptr_q] <= '{tag: res_tag, exc: res_exc, data: res_data};
    end
  end

  assign head     = mem_q[rd_ptr_q];
  assign rd_data  = is_empty ? 32'b0 : head.data;
  assign rd_exc   = is_empty ? 5'b0  : head.exc;
  assign rd_tag   = is_empty ? 4'b0  : head.tag;
  assign count    = count_q;
  assign empty    = is_empty;
  assign full     = is_full;
  assign overflow = overflow_q;
  assign fflags   = fflags_q;
  assign irq      = (count_q >= THRESH_C) | overflow_q;

endmodule

// File: tb/tb_fpu_result_fifo.sv
module tb_fpu_result_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid, pop, flush, clr_flags;
  logic [31:0] res_data;
  logic [4:0]  res_exc;
  logic [3:0]  res_tag;
  logic [31:0] rd_data;
  logic [4:0]  rd_exc;
  logic [3:0]  rd_tag;
  logic [3:0]  count;
  logic        empty, full, overflow, irq;
  logic [4:0]  fflags;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fpu_result_fifo #(.DEPTH(8), .AW(3), .IRQ_THRESH(1)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .res_valid(res_valid),
    .res_data (res_data),
    .res_exc  (res_exc),
    .res_tag  (res_tag),
    .pop      (pop),
    .flush    (flush),
    .clr_flags(clr_flags),
    .rd_data  (rd_data),
    .rd_exc   (rd_exc),
    .rd_tag   (rd_tag),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .fflags   (fflags),
    .irq      (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    res_valid = 0; pop = 0; flush = 0; clr_flags = 0;
    res_data = '0; res_exc = '0; res_tag = '0;
  endtask

  task automatic push(input logic [31:0] d, input logic [4:0] e, input logic [3:0] t);
    res_valid = 1; res_data = d; res_exc = e; res_tag = t;
    step();
    idle();
  endtask

  task automatic do_pop();
    pop = 1;
    step();
    idle();
  endtask

  initial begin
    idle();
    rst = 1;
    step(); step();
    rst = 0;
    step();

    // Reset / idle state
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_fflags", 32'(fflags), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_full", 32'(full), 32'd0);

    // Pop while empty has no effect
    do_pop();
    chk("pop_empty_count", 32'(count), 32'd0);
    chk("pop_empty_empty", 32'(empty), 32'd1);
    chk("pop_empty_irq", 32'(irq), 32'd0);

    // Single push, fall-through, pop
    push(32'h3F80_0000, 5'b0, 4'd6);
    chk("one_rd_data", rd_data, 32'h3F80_0000);
    chk("one_rd_tag", 32'(rd_tag), 32'd6);
    chk("one_count", 32'(count), 32'd1);
    chk("one_irq", 32'(irq), 32'd1);
    do_pop();
    chk("one_pop_empty", 32'(empty), 32'd1);
    chk("one_pop_irq", 32'(irq), 32'd0);

    // Fill to full, then overflow drop
    for (int i = 0; i < 8; i++) push(32'(i), 5'b0, 4'(i));
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd8);
    push(32'h0000_DEAD, 5'b10000, 4'd2);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_fflags", 32'(fflags), 32'b10000);
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_irq", 32'(irq), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain_%0d", i), rd_data, 32'(i));
      chk($sformatf("drain_tag_%0d", i), 32'(rd_tag), 32'(i));
      do_pop();
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_irq_ovf", 32'(irq), 32'd1);

    // Clear flags alone
    clr_flags = 1;
    step();
    idle();
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_fflags", 32'(fflags), 32'd0);
    chk("clr_irq", 32'(irq), 32'd0);

    // Full with simultaneous push and pop (pointers wrap)
    for (int i = 0; i < 8; i++) push(32'h100 + 32'(i), 5'b0, 4'd1);
    res_valid = 1; res_data = 32'h200; res_tag = 4'd3; pop = 1;
    step();
    idle();
    chk("pp_count", 32'(count), 32'd8);
    chk("pp_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("pp_drain_%0d", i), rd_data, 32'h100 + 32'(i));
      do_pop();
    end
    chk("pp_last", rd_data, 32'h200);
    chk("pp_last_tag", 32'(rd_tag), 32'd3);
    do_pop();
    chk("pp_empty", 32'(empty), 32'd1);

    // Push and pop together while empty: push stored, count 1
    res_valid = 1; res_data = 32'h77; res_tag = 4'd4; pop = 1;
    step();
    idle();
    chk("ep_count", 32'(count), 32'd1);
    chk("ep_rd_data", rd_data, 32'h77);
    do_pop();

    // fflags accumulate and clear-with-new-flag
    push(32'h55, 5'b00001, 4'd0);
    chk("ff_acc", 32'(fflags), 32'b00001);
    chk("ff_rd_exc", 32'(rd_exc), 32'b00001);
    res_valid = 1; res_data = 32'h66; res_exc = 5'b01000; clr_flags = 1;
    step();
    idle();
    chk("ff_clr_new", 32'(fflags), 32'b01000);
    chk("ff_clr_ovf", 32'(overflow), 32'd0);
    chk("ff_count", 32'(count), 32'd2);

    // Flush with concurrent res_valid and 3 entries held
    push(32'h77, 5'b0, 4'd0);
    chk("pre_flush_count", 32'(count), 32'd3);
    flush = 1; res_valid = 1; res_data = 32'h88; res_exc = 5'b00010;
    step();
    idle();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_ovf", 32'(overflow), 32'd0);
    chk("flush_fflags", 32'(fflags), 32'b01010);
    chk("flush_rd_data", rd_data, 32'd0);
    chk("flush_irq", 32'(irq), 32'd0);

    // Reset mid-operation
    push(32'hAA, 5'b00100, 4'd9);
    push(32'hBB, 5'b0, 4'd10);
    chk("pre_rst_count", 32'(count), 32'd2);
    rst = 1;
    step();
    rst = 0;
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_empty", 32'(empty), 32'd1);
    chk("mrst_rd_data", rd_data, 32'd0);
    chk("mrst_rd_tag", 32'(rd_tag), 32'd0);
    chk("mrst_rd_exc", 32'(rd_exc), 32'd0);
    chk("mrst_fflags", 32'(fflags), 32'd0);
    chk("mrst_ovf", 32'(overflow), 32'd0);
    chk("mrst_irq", 32'(irq), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
